conv_layer_sequencer: RTL and testbench

Sequences one `conv_layer` instance through a full inference pass: loads its memories from a single upstream word stream, launches the convolution, waits for completion, then drains the output memory as a downstream stream. Sits between the network-level data mover and the conv layer, and owns every layer control pin (`want_write_*`, `in_index*`, `compute`, `read_outmem_index`). Data words are opaque `DATA_SIZE`-bit IEEE-754 double bit patterns.

---
 rtl/conv_layer_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Sequences a conv_layer through load, compute and drain. Define CONV_SEQ_RELU_EN to zero
// negative drained words (ReLU); undefined, drained words pass through unmodified.
module conv_layer_sequencer #(
    parameter int unsigned NUM_INPUTS   = 1,
    parameter int unsigned INPUT_DIM    = 5,
    parameter int unsigned NUM_OUTPUTS  = 1,
    parameter int unsigned KERNEL_DIM   = 3,
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 want_write_weights,
    output logic                 want_write_bias,
    output logic                 want_write_act,
    output logic [DATA_SIZE-1:0] write_data,
    output logic [15:0]          in_index3,
    output logic [15:0]          in_index2,
    output logic [15:0]          in_index1,
    output logic [15:0]          in_index0,
    output logic                 compute,
    input  logic                 layer_output_valid,
    output logic [15:0]          read_outmem_index2,
    output logic [15:0]          read_outmem_index1,
    output logic [15:0]          read_outmem_index0,
    input  logic [DATA_SIZE-1:0] outmem_out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_last
);

    localparam int unsigned OUTPUT_DIM   = INPUT_DIM - KERNEL_DIM + 1;
    localparam int unsigned GUARD_CYCLES = 2;

    localparam logic [15:0] KMAX  = 16'(KERNEL_DIM - 1);
    localparam logic [15:0] IDMAX = 16'(INPUT_DIM - 1);
    localparam logic [15:0] ODMAX = 16'(OUTPUT_DIM - 1);
    localparam logic [15:0] NIMAX = 16'(NUM_INPUTS - 1);
    localparam logic [15:0] NOMAX = 16'(NUM_OUTPUTS - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLoadW,
        StLoadB,
        StLoadA,
        StCompute,
        StWait,
        StDrainRd,
        StDrainOut,
        StDone
    } state_e;

    state_e state_q, state_d;

    // One shared index nest; its per-state limits give every phase its own loop order.
    logic [15:0] c0_q, c1_q, c2_q, c3_q;
    logic [15:0] c0_d, c1_d, c2_d, c3_d;
    logic [15:0] c0_n, c1_n, c2_n, c3_n;
    logic [15:0] lim0, lim1, lim2, lim3;
    logic        at0, at1, at2, at3, last;

    logic [15:0] lat_q, lat_d;

    logic                 ww_q, wb_q, wa_q;
    logic                 ww_d, wb_d, wa_d;
    logic [DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [15:0]          idx3_q, idx2_q, idx1_q, idx0_q;
    logic [15:0]          idx3_d, idx2_d, idx1_d, idx0_d;
    logic [DATA_SIZE-1:0] odata_q, odata_d;
    logic [DATA_SIZE-1:0] captured;
    logic                 draining;

    always_comb begin
        lim0 = '0;
        lim1 = '0;
        lim2 = '0;
        lim3 = '0;
        case (state_q)
            StLoadW: begin
                lim0 = KMAX;
                lim1 = KMAX;
                lim2 = NOMAX;
                lim3 = NIMAX;
            end
            StLoadB: lim2 = NOMAX;
            StLoadA: begin
                lim0 = IDMAX;
                lim1 = IDMAX;
                lim2 = NIMAX;
            end
            StDrainRd, StDrainOut: begin
                lim0 = ODMAX;
                lim1 = ODMAX;
                lim2 = NOMAX;
            end
            default: ;
        endcase
    end

    always_comb begin
        at0  = (c0_q == lim0);
        at1  = (c1_q == lim1);
        at2  = (c2_q == lim2);
        at3  = (c3_q == lim3);
        last = at0 & at1 & at2 & at3;
        c0_n = at0 ? 16'd0 : c0_q + 16'd1;
        c1_n = at0 ? (at1 ? 16'd0 : c1_q + 16'd1) : c1_q;
        c2_n = (at0 & at1) ? (at2 ? 16'd0 : c2_q + 16'd1) : c2_q;
        c3_n = (at0 & at1 & at2) ? (at3 ? 16'd0 : c3_q + 16'd1) : c3_q;
    end

    always_comb begin
        captured = outmem_out_data;
`ifdef CONV_SEQ_RELU_EN
        if (outmem_out_data[DATA_SIZE-1]) begin
            captured = '0;
        end
`endif
    end

    assign in_ready = (state_q == StLoadW) || (state_q == StLoadB) || (state_q == StLoadA);
    assign draining = (state_q == StDrainRd) || (state_q == StDrainOut);

    always_comb begin
        state_d = state_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        lat_d   = lat_q;
        ww_d    = 1'b0;
        wb_d    = 1'b0;
        wa_d    = 1'b0;
        wdata_d = wdata_q;
        idx3_d  = idx3_q;
        idx2_d  = idx2_q;
        idx1_d  = idx1_q;
        idx0_d  = idx0_q;
        odata_d = odata_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoadW;
                    c0_d    = '0;
                    c1_d    = '0;
                    c2_d    = '0;
                    c3_d    = '0;
                    lat_d   = '0;
                end
            end
            StLoadW, StLoadB, StLoadA: begin
                if (in_valid) begin
                    ww_d    = (state_q == StLoadW);
                    wb_d    = (state_q == StLoadB);
                    wa_d    = (state_q == StLoadA);
                    wdata_d = in_data;
                    idx3_d  = c3_q;
                    idx2_d  = c2_q;
                    idx1_d  = c1_q;
                    idx0_d  = c0_q;
                    c0_d    = c0_n;
                    c1_d    = c1_n;
                    c2_d    = c2_n;
                    c3_d    = c3_n;
                    if (last) begin
                        case (state_q)
                            StLoadW: state_d = StLoadB;
                            StLoadB: state_d = StLoadA;
                            default: state_d = StCompute;
                        endcase
                    end
                end
            end
            StCompute: begin
                state_d = StWait;
                lat_d   = '0;
            end
            StWait: begin
                // The layer may still show valid from the previous pass right after launch.
                if (lat_q < 16'(GUARD_CYCLES)) begin
                    lat_d = lat_q + 16'd1;
                end else if (layer_output_valid) begin
                    state_d = StDrainRd;
                    lat_d   = '0;
                end
            end
            StDrainRd: begin
                if (lat_q == 16'(READ_LATENCY)) begin
                    odata_d = captured;
                    state_d = StDrainOut;
                end else begin
                    lat_d = lat_q + 16'd1;
                end
            end
            StDrainOut: begin
                if (out_ready) begin
                    c0_d    = c0_n;
                    c1_d    = c1_n;
                    c2_d    = c2_n;
                    c3_d    = c3_n;
                    lat_d   = '0;
                    state_d = last ? StDone : StDrainRd;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            c0_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            lat_q   <= '0;
            ww_q    <= 1'b0;
            wb_q    <= 1'b0;
            wa_q    <= 1'b0;
            wdata_q <= '0;
            idx3_q  <= '0;
            idx2_q  <= '0;
            idx1_q  <= '0;
            idx0_q  <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            lat_q   <= lat_d;
            ww_q    <= ww_d;
            wb_q    <= wb_d;
            wa_q    <= wa_d;
            wdata_q <= wdata_d;
            idx3_q  <= idx3_d;
            idx2_q  <= idx2_d;
            idx1_q  <= idx1_d;
            idx0_q  <= idx0_d;
            odata_q <= odata_d;
        end
    end

    assign busy               = (state_q != StIdle);
    assign done               = (state_q == StDone);
    assign compute            = (state_q == StCompute);
    assign want_write_weights = ww_q;
    assign want_write_bias    = wb_q;
    assign want_write_act     = wa_q;
    assign write_data         = wdata_q;
    assign in_index3          = idx3_q;
    assign in_index2          = idx2_q;
    assign in_index1          = idx1_q;
    assign in_index0          = idx0_q;
    assign read_outmem_index2 = draining ? c2_q : 16'd0;
    assign read_outmem_index1 = draining ? c1_q : 16'd0;
    assign read_outmem_index0 = draining ? c0_q : 16'd0;
    assign out_valid          = (state_q == StDrainOut);
    assign out_last           = (state_q == StDrainOut) && last;
    assign out_data           = odata_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer with a behavioural conv_layer model
// (registered output memory read, completion flag 50 cycles after launch).
module tb_conv_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        want_write_weights, want_write_bias, want_write_act;
    logic [63:0] write_data;
    logic [15:0] in_index3, in_index2, in_index1, in_index0;
    logic        compute;
    logic        layer_output_valid;
    logic [15:0] read_outmem_index2, read_outmem_index1, read_outmem_index0;
    logic [63:0] outmem_out_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_last;

    always #5 clk = ~clk;

    conv_layer_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .want_write_weights (want_write_weights),
        .want_write_bias    (want_write_bias),
        .want_write_act     (want_write_act),
        .write_data         (write_data),
        .in_index3          (in_index3),
        .in_index2          (in_index2),
        .in_index1          (in_index1),
        .in_index0          (in_index0),
        .compute            (compute),
        .layer_output_valid (layer_output_valid),
        .read_outmem_index2 (read_outmem_index2),
        .read_outmem_index1 (read_outmem_index1),
        .read_outmem_index0 (read_outmem_index0),
        .outmem_out_data    (outmem_out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_last           (out_last)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] i3, i2, i1, i0;
        logic [63:0] d;
    } wr_t;
    typedef struct packed {
        logic [15:0] e, y, x;
        logic [63:0] d;
    } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];
    logic [63:0] mem [0:8];

    function automatic logic [63:0] relu_exp(input logic [63:0] v);
`ifdef CONV_SEQ_RELU_EN
        return v[63] ? 64'd0 : v;
`else
        return v;
`endif
    endfunction

    // Layer model: cycle k after launch has lv_cnt == k; the flag stays high until next launch.
    int lv_cnt = 0;
    bit stale_mode = 1'b0;
    always @(posedge clk) begin
        int a;
        a = int'(read_outmem_index2) * 9 + int'(read_outmem_index1) * 3 + int'(read_outmem_index0);
        outmem_out_data <= (a < 9) ? mem[a] : 64'hDEAD_DEAD_DEAD_DEAD;
        if (compute) lv_cnt <= 1;
        else if (lv_cnt > 0 && lv_cnt < 50) lv_cnt <= lv_cnt + 1;
    end
    assign layer_output_valid = (lv_cnt >= 50) || (stale_mode && lv_cnt >= 1 && lv_cnt <= 2);

    int   cyc = 0, compute_cyc = 0, n_compute = 0, n_done = 0;
    bit   first_out = 1'b0, prev_done = 1'b0, tgl_ready = 1'b0;
    wr_t  exp_w;
    rd_t  exp_r;
    logic [1:0] kind;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (prev_done) check_val("busy_after_done", 64'(busy), 64'd0);
            prev_done = done;
            if (done) n_done++;
            if (compute) begin
                n_compute++;
                compute_cyc = cyc;
                first_out   = 1'b1;
            end
            if (want_write_weights || want_write_bias || want_write_act) begin
                check_val("one_strobe", 64'(int'(want_write_weights) + int'(want_write_bias)
                          + int'(want_write_act)), 64'd1);
                if (wr_q.size() == 0) begin
                    check_val("write_expected", 64'(wr_q.size()), 64'd1);
                end else begin
                    exp_w = wr_q.pop_front();
                    kind  = want_write_bias ? 2'd1 : (want_write_act ? 2'd2 : 2'd0);
                    check_val("wr_kind", 64'(kind), 64'(exp_w.kind));
                    check_val("wr_idx", {in_index3, in_index2, in_index1, in_index0},
                              {exp_w.i3, exp_w.i2, exp_w.i1, exp_w.i0});
                    check_val("wr_data", write_data, exp_w.d);
                end
            end
            out_ready = tgl_ready ? !out_ready : 1'b1;
            if (out_valid) begin
                if (first_out) begin
                    check_val("drain_latency", 64'(cyc - compute_cyc), 64'd53);
                    first_out = 1'b0;
                end
                if (rd_q.size() == 0) begin
                    check_val("drain_expected", 64'(rd_q.size()), 64'd1);
                end else begin
                    exp_r = rd_q[0];
                    check_val("out_data", out_data, exp_r.d);
                    check_val("rd_idx", {16'd0, read_outmem_index2, read_outmem_index1,
                              read_outmem_index0}, {16'd0, exp_r.e, exp_r.y, exp_r.x});
                    check_val("out_last", 64'(out_last), 64'(rd_q.size() == 1));
                    if (out_ready) void'(rd_q.pop_front());
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        check_val({tag, "_ctrl"}, 64'({in_ready, busy, done, compute, out_valid, out_last,
                  want_write_weights, want_write_bias, want_write_act}), 64'd0);
        check_val({tag, "_wdata"}, write_data, 64'd0);
        check_val({tag, "_widx"}, {in_index3, in_index2, in_index1, in_index0}, 64'd0);
        check_val({tag, "_ridx"}, {16'd0, read_outmem_index2, read_outmem_index1,
                  read_outmem_index0}, 64'd0);
        check_val({tag, "_odata"}, out_data, 64'd0);
    endtask

    task automatic send(input logic [1:0] k, input int i3, input int i2, input int i1,
                        input int i0, input bit bubble);
        logic [63:0] d;
        int guard;
        d     = {$urandom, $urandom};
        guard = 0;
        if (bubble) begin
            in_valid = 1'b0;
            in_data  = ~d;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_val("in_ready_timeout", 64'(in_ready), 64'd1);
        else wr_q.push_back({k, 16'(i3), 16'(i2), 16'(i1), 16'(i0), d});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_pass(input bit bubbles, input bit abort);
        int k, g;
        k = 0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                rd_q.push_back({16'd0, 16'(y), 16'(x), relu_exp(mem[y * 3 + x])});
        n_compute = 0;
        n_done    = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int kx = 0; kx < 9; kx++) begin
            send(2'd0, 0, 0, kx / 3, kx % 3, bubbles && (k % 3 == 2));
            k++;
        end
        send(2'd1, 0, 0, 0, 0, bubbles);
        for (int a = 0; a < 25; a++) begin
            if (abort && a == 10) begin
                rst = 1'b1;
                #1;
                check_quiet("rst_abort");
                wr_q.delete();
                rd_q.delete();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            send(2'd2, 0, 0, a / 5, a % 5, bubbles && (k % 3 == 2));
            k++;
        end
        check_val("in_ready_after_last", 64'(in_ready), 64'd0);
        g = 0;
        while (n_done == 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        check_val("done_pulses", 64'(n_done), 64'd1);
        check_val("compute_pulses", 64'(n_compute), 64'd1);
        check_val("drain_left", 64'(rd_q.size()), 64'd0);
        check_val("write_left", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) mem[i] = {$urandom, $urandom};
        mem[4] = 64'hC004_0000_0000_0000;  // -2.5
        mem[5] = 64'h4008_0000_0000_0000;  // 3.0
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        run_pass(1'b0, 1'b0);

        for (int i = 0; i < 9; i++) if (i != 4 && i != 5) mem[i] = {$urandom, $urandom};
        stale_mode = 1'b1;
        tgl_ready  = 1'b1;
        run_pass(1'b1, 1'b0);
        stale_mode = 1'b0;
        tgl_ready  = 1'b0;

        run_pass(1'b0, 1'b1);
        run_pass(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
